// File: rtl/regfile_sb_if.sv
// regfile_sb_if -- bus bundle for the scoreboarded register file.
//   master modport: drives read/write/claim requests (ra, we, wa, wd,
//                   claim_en, claim_a); observes rd, rbusy, claim_ok.
//   slave modport : the register file side (directions reversed).
// Field packing: read port i uses ra[i*AW +: AW] / rd[i*WIDTH +: WIDTH];
// write port j uses wa[j*AW +: AW] / wd[j*WIDTH +: WIDTH].
interface regfile_sb_if #(
    parameter int unsigned NUM_REG = 32,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NUM_RD  = 2,
    parameter int unsigned NUM_WR  = 2
);
    localparam int unsigned AW = $clog2(NUM_REG);

    logic [NUM_RD*AW-1:0]    ra;
    logic [NUM_RD*WIDTH-1:0] rd;
    logic [NUM_RD-1:0]       rbusy;
    logic [NUM_WR-1:0]       we;
    logic [NUM_WR*AW-1:0]    wa;
    logic [NUM_WR*WIDTH-1:0] wd;
    logic                    claim_en;
    logic [AW-1:0]           claim_a;
    logic                    claim_ok;

    modport master (
        output ra, we, wa, wd, claim_en, claim_a,
        input  rd, rbusy, claim_ok
    );

    modport slave (
        input  ra, we, wa, wd, claim_en, claim_a,
        output rd, rbusy, claim_ok
    );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb -- multi-ported register file with a per-register pending
// (scoreboard) bit.
//   clk   : single clock, all state updates on the rising edge.
//   reset : asynchronous, active-low; clears registers and pending bits.
//   bus   : regfile_sb_if.slave -- NUM_RD async read ports (rd, rbusy),
//           NUM_WR sync write ports (highest index wins on collision),
//           one claim port (claim_en/claim_a, combinational claim_ok).
// Register 0 reads as 0, ignores writes and is never pending.
// Optional feature: define REGFILE_SB_BYPASS_EN to forward same-cycle
// write data to the read ports (rbusy then reads 0 for that port).
module regfile_sb #(
    parameter int unsigned NUM_REG = 32,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NUM_RD  = 2,
    parameter int unsigned NUM_WR  = 2
) (
    input  logic         clk,
    input  logic         reset,
    regfile_sb_if.slave  bus
);
    localparam int unsigned AW = $clog2(NUM_REG);

    logic [WIDTH-1:0]    regs_q [NUM_REG];
    logic [WIDTH-1:0]    regs_d [NUM_REG];
    logic [NUM_REG-1:0]  pend_q;
    logic [NUM_REG-1:0]  pend_d;

    logic                claim_wr_hit;
    logic                claim_ok;
    logic [NUM_RD*WIDTH-1:0] rd_v;
    logic [NUM_RD-1:0]   rbusy_v;

    // A write to the claimed register in the same cycle lets a claim
    // through even if the register is currently pending.
    always_comb begin
        claim_wr_hit = 1'b0;
        for (int unsigned j = 0; j < NUM_WR; j++) begin
            if (bus.we[j] && (bus.wa[j*AW +: AW] == bus.claim_a))
                claim_wr_hit = 1'b1;
        end
    end

    always_comb begin
        claim_ok = !reset || !bus.claim_en || (bus.claim_a == '0) ||
                   !pend_q[bus.claim_a] || claim_wr_hit;
    end

    // Next state: writes applied in ascending port order so the highest
    // index wins; an accepted claim is applied last so it overrides the
    // pending-clear of a same-cycle write.
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        for (int unsigned j = 0; j < NUM_WR; j++) begin
            if (bus.we[j] && (bus.wa[j*AW +: AW] != '0)) begin
                regs_d[bus.wa[j*AW +: AW]] = bus.wd[j*WIDTH +: WIDTH];
                pend_d[bus.wa[j*AW +: AW]] = 1'b0;
            end
        end
        if (bus.claim_en && (bus.claim_a != '0) && claim_ok)
            pend_d[bus.claim_a] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned k = 0; k < NUM_REG; k++)
                regs_q[k] <= '0;
            pend_q <= '0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
        end
    end

    // Read ports; outputs are forced to 0 while reset is asserted so that
    // forwarded write data cannot leak out during reset.
    always_comb begin
        rd_v    = '0;
        rbusy_v = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            if (reset && (bus.ra[i*AW +: AW] != '0)) begin
                rd_v[i*WIDTH +: WIDTH] = regs_q[bus.ra[i*AW +: AW]];
                rbusy_v[i]             = pend_q[bus.ra[i*AW +: AW]];
`ifdef REGFILE_SB_BYPASS_EN
                for (int unsigned j = 0; j < NUM_WR; j++) begin
                    if (bus.we[j] && (bus.wa[j*AW +: AW] == bus.ra[i*AW +: AW])) begin
                        rd_v[i*WIDTH +: WIDTH] = bus.wd[j*WIDTH +: WIDTH];
                        rbusy_v[i]             = 1'b0;
                    end
                end
`else
`endif
            end
        end
    end

    assign bus.rd       = rd_v;
    assign bus.rbusy    = rbusy_v;
    assign bus.claim_ok = claim_ok;
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb -- directed self-checking bench for regfile_sb with the
// default configuration (32 x 32-bit, 2 read ports, 2 write ports).
// Expected values for the same-cycle read-after-write steps depend on
// whether REGFILE_SB_BYPASS_EN is defined for the build.
module tb_regfile_sb;
    logic clk;
    logic reset;

    int unsigned n_asserts;
    int unsigned n_fail;

    regfile_sb_if #(.NUM_REG(32), .WIDTH(32), .NUM_RD(2), .NUM_WR(2)) bus ();

    regfile_sb #(.NUM_REG(32), .WIDTH(32), .NUM_RD(2), .NUM_WR(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.we       = '0;
        bus.wa       = '0;
        bus.wd       = '0;
        bus.claim_en = 1'b0;
        bus.claim_a  = '0;
    endtask

    initial begin
        n_asserts = 0;
        n_fail    = 0;
        reset     = 1'b0;
        idle();
        bus.ra    = '0;

        // Write presented during reset must be discarded.
        bus.we = 2'b01; bus.wa = {5'd0, 5'd5}; bus.wd = {32'h0, 32'hFFFF_FFFF};
        bus.ra = {5'd0, 5'd5};
        #12;
        chk("rst_rd",       bus.rd[31:0],            32'h0);
        chk("rst_rbusy",    {30'h0, bus.rbusy},      32'h0);
        chk("rst_claim_ok", {31'h0, bus.claim_ok},   32'h1);
        #10;
        idle();
        reset = 1'b1;
        tick();
        chk("rst_discard_wr", bus.rd[31:0], 32'h0);

        // Basic write then read; port 1 reads register 0.
        bus.we = 2'b01; bus.wa = {5'd0, 5'd5}; bus.wd = {32'h0, 32'hDEAD_BEEF};
        tick();
        idle();
        bus.ra = {5'd0, 5'd5};
        #1;
        chk("wr5_rd0", bus.rd[31:0],  32'hDEAD_BEEF);
        chk("r0_rd1",  bus.rd[63:32], 32'h0);

        // Both ports write register 7; port 1 wins.
        bus.we = 2'b11; bus.wa = {5'd7, 5'd7}; bus.wd = {32'd2, 32'd1};
        tick();
        idle();
        bus.ra = {5'd5, 5'd7};
        #1;
        chk("wr_prio",   bus.rd[31:0],  32'd2);
        chk("rd1_keep5", bus.rd[63:32], 32'hDEAD_BEEF);

        // Claim register 9.
        bus.claim_en = 1'b1; bus.claim_a = 5'd9;
        #1;
        chk("claim9_ok", {31'h0, bus.claim_ok}, 32'h1);
        tick();
        bus.ra = {5'd0, 5'd9};
        #1;
        chk("rbusy9",     {31'h0, bus.rbusy[0]}, 32'h1);
        chk("rbusy_r0",   {31'h0, bus.rbusy[1]}, 32'h0);
        chk("claim9_rej", {31'h0, bus.claim_ok}, 32'h0);
        // Rejected claim through an edge changes nothing.
        tick();
        chk("rej_keep_busy", {31'h0, bus.rbusy[0]}, 32'h1);

        // Write 9 with 3 clears the pending bit.
        idle();
        bus.we = 2'b01; bus.wa = {5'd0, 5'd9}; bus.wd = {32'h0, 32'd3};
        #1;
`ifdef REGFILE_SB_BYPASS_EN
        chk("wr9_same_busy", {31'h0, bus.rbusy[0]}, 32'h0);
        chk("wr9_same_rd",   bus.rd[31:0],          32'd3);
`else
        chk("wr9_same_busy", {31'h0, bus.rbusy[0]}, 32'h1);
        chk("wr9_same_rd",   bus.rd[31:0],          32'd0);
`endif
        tick();
        idle();
        #1;
        chk("wr9_busy_clr", {31'h0, bus.rbusy[0]}, 32'h0);
        chk("wr9_rd",       bus.rd[31:0],          32'd3);

        // Re-claim 9, then claim + write 9 in one cycle while pending;
        // port 1 also writes register 0.
        bus.claim_en = 1'b1; bus.claim_a = 5'd9;
        tick();
        chk("reclaim9_busy", {31'h0, bus.rbusy[0]}, 32'h1);
        bus.we = 2'b11; bus.wa = {5'd0, 5'd9}; bus.wd = {32'd1, 32'd4};
        #1;
        chk("claim_wr_ok", {31'h0, bus.claim_ok}, 32'h1);
        tick();
        idle();
        #1;
        chk("claim_wins_busy", {31'h0, bus.rbusy[0]}, 32'h1);
        chk("claim_wr_data",   bus.rd[31:0],          32'd4);
        chk("r0_ignore_wr",    bus.rd[63:32],         32'd0);

        // Claim and write register 4, then reset mid-cycle.
        bus.claim_en = 1'b1; bus.claim_a = 5'd4;
        bus.we = 2'b01; bus.wa = {5'd0, 5'd4}; bus.wd = {32'h0, 32'h0000_00AA};
        tick();
        idle();
        bus.ra = {5'd9, 5'd4};
        #1;
        chk("r4_pre_rd",    bus.rd[31:0],           32'h0000_00AA);
        chk("r4_pre_busy",  {31'h0, bus.rbusy[0]},  32'h1);
        bus.claim_en = 1'b1; bus.claim_a = 5'd9;
        #1;
        chk("pre_rst_rej",  {31'h0, bus.claim_ok},  32'h0);
        #1;
        reset = 1'b0;
        #1;
        chk("mid_rst_rd0",   bus.rd[31:0],           32'h0);
        chk("mid_rst_rd1",   bus.rd[63:32],          32'h0);
        chk("mid_rst_rbusy", {30'h0, bus.rbusy},     32'h0);
        chk("mid_rst_ok",    {31'h0, bus.claim_ok},  32'h1);
        tick();
        idle();
        #2;
        reset = 1'b1;
        tick();
        chk("post_rst_r4",   bus.rd[31:0],           32'h0);
        chk("post_rst_busy", {30'h0, bus.rbusy},     32'h0);

        // Same-cycle read of a register being written.
        bus.we = 2'b01; bus.wa = {5'd0, 5'd3}; bus.wd = {32'h0, 32'h11};
        tick();
        idle();
        bus.ra = {5'd0, 5'd3};
        bus.we = 2'b01; bus.wa = {5'd0, 5'd3}; bus.wd = {32'h0, 32'h55};
        #1;
`ifdef REGFILE_SB_BYPASS_EN
        chk("raw_same", bus.rd[31:0], 32'h55);
`else
        chk("raw_same", bus.rd[31:0], 32'h11);
`endif
        tick();
        idle();
        #1;
        chk("raw_after", bus.rd[31:0], 32'h55);

        // Colliding writes to 6, read on both ports in the same cycle.
        bus.ra = {5'd6, 5'd6};
        bus.we = 2'b11; bus.wa = {5'd6, 5'd6}; bus.wd = {32'hBB, 32'hAA};
        #1;
`ifdef REGFILE_SB_BYPASS_EN
        chk("byp_prio", bus.rd[63:32], 32'hBB);
`else
        chk("byp_prio", bus.rd[63:32], 32'h0);
`endif
        tick();
        idle();
        #1;
        chk("prio6_after", bus.rd[31:0], 32'hBB);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter NUM_REG, default 32: number of registers; power of two, at least 2.
REQ-002 Parameter WIDTH, default 32: data bits per register.
REQ-003 Parameter NUM_RD, default 2: number of asynchronous read ports.
REQ-004 Parameter NUM_WR, default 2: number of synchronous write ports.
REQ-005 Local AW SHALL equal $clog2(NUM_REG).
REQ-006 clk  in  1: single clock; all state updates on its rising edge.
REQ-007 reset  in  1: asynchronous reset, active-low; asserted when 0.
REQ-008 ra  in  NUM_RD*AW: read addresses, flattened; port i occupies bits [i*AW +: AW].
REQ-009 rd  out  NUM_RD*WIDTH: read data, flattened; port i occupies bits [i*WIDTH +: WIDTH].
REQ-010 rbusy  out  NUM_RD: port i's addressed register has a pending write.
REQ-011 we  in  NUM_WR: write enable per write port.
REQ-012 wa  in  NUM_WR*AW: write addresses, flattened.
REQ-013 wd  in  NUM_WR*WIDTH: write data, flattened.
REQ-014 claim_en  in  1: request to mark register claim_a as pending.
REQ-015 claim_a  in  AW: register to claim.
REQ-016 claim_ok  out  1: combinational; claim is accepted this cycle.

Function
REQ-017 rd[i] SHALL equal register ra[i] combinationally; rd[i] SHALL be 0 when ra[i]==0.
REQ-018 Register 0 SHALL always read 0, ignore writes, and never be pending.
REQ-019 A write on port j with we[j]=1 and wa[j]!=0 SHALL update the register at the next rising edge.
REQ-020 If two or more write ports target the same address in one cycle, the highest-index port SHALL win.
REQ-021 Each register SHALL have one pending bit.
- Any accepted write to a register SHALL clear its pending bit at the same edge.
REQ-022 claim_ok SHALL be 1 when claim_en=0, claim_a==0, or the pending bit of claim_a is 0.
- claim_ok SHALL also be 1 when a write to claim_a occurs in the same cycle.
- claim_ok SHALL be 0 otherwise.
REQ-023 An accepted claim with claim_a!=0 SHALL set the pending bit at the next edge.
- If a write to the same register occurs in the same cycle, the claim SHALL take priority and the bit SHALL end set.
REQ-024 A rejected claim (claim_ok=0) SHALL leave all state unchanged.
REQ-025 rbusy[i] SHALL equal the current pending bit of ra[i]; rbusy[i] SHALL be 0 when ra[i]==0.
REQ-026 Read latency SHALL be 0 cycles. Write-to-read latency SHALL be 1 edge, except as stated in REQ-032.

Reset
REQ-027 While reset==0, all registers and all pending bits SHALL be cleared to 0 asynchronously.
REQ-028 During reset, rd SHALL be all 0, rbusy SHALL be all 0, and claim_ok SHALL be 1.
REQ-029 Writes and claims presented during reset SHALL be discarded.
REQ-030 Reset asserted mid-operation SHALL cancel all pending claims.
REQ-031 Reset deassertion SHALL take effect at the first rising edge after reset returns to 1.

Configuration
REQ-032 With macro REGFILE_SB_BYPASS_EN defined, the block SHALL forward write data within the same cycle.
- If any we[j]=1 and wa[j]==ra[i]!=0, rd[i] SHALL equal the winning wd[j] in that same cycle (priority per REQ-020).
- rbusy[i] SHALL read 0 in that cycle.
REQ-033 With REGFILE_SB_BYPASS_EN undefined, reads SHALL return stored contents only.
- Write data SHALL become visible after the edge.

Verification
REQ-034 Reset, then we[0]=1, wa[0]=5, wd[0]=32'hDEADBEEF; next cycle ra[0]=5 -> rd[0]=32'hDEADBEEF; ra[1]=0 -> rd[1]=0.
REQ-035 Same cycle: we[0]=1 and we[1]=1, wa=7 on both ports, wd[0]=1, wd[1]=2 -> register 7 reads 2.
REQ-036 claim_en=1, claim_a=9 -> claim_ok=1.
- Next cycle: ra[0]=9 -> rbusy[0]=1; a second claim of 9 -> claim_ok=0.
- Then write 9 with data 3 -> rbusy[0]=0 after the edge and rd[0]=3.
REQ-037 Claim 9 and write 9 in the same cycle while 9 is pending -> claim_ok=1 and pending remains set; also, a write to 0 with data 1 -> register 0 reads 0.
REQ-038 Claim 4 and write register 4 with 8'hAA, then drive reset=0 between edges.
- rd and rbusy SHALL go to 0 immediately; claim_ok SHALL be 1.
- After release, register 4 SHALL read 0.
REQ-039 Build with REGFILE_SB_BYPASS_EN: we[0]=1, wa[0]=3, wd[0]=8'h55, ra[0]=3 -> rd[0]=8'h55 in the same cycle.
- Build without the macro: the same stimulus gives rd[0]=old value in that cycle and 8'h55 after the edge.
